// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings, access sizes and responder states
// for the MEM-stage data-memory port.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Only the low three address bits matter for natural alignment.
  function automatic logic is_aligned(
    input logic [2:0] addr,
    input mem_size_t  size
  );
    logic ok;
    unique case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~addr[0];
      SZ_W:    ok = ~|addr[1:0];
      default: ok = ~|addr[2:0];
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/shift and load extract/extend
// for one 64-bit little-endian doubleword.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  offset,
  input  mem_size_t   size,
  input  logic        zext,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  bmask,
  output logic [63:0] wshift,
  output logic [63:0] ldata
);

  logic [5:0]  sh;
  logic [7:0]  base;
  logic [63:0] lanes;

  assign sh = {offset, 3'b000};

  always_comb begin
    base  = 8'h01;
    ldata = '0;
    lanes = rword >> sh;
    unique case (1'b1)
      (size == SZ_B): begin
        base  = 8'h01;
        ldata = {{56{~zext & lanes[7]}}, lanes[7:0]};
      end
      (size == SZ_H): begin
        base  = 8'h03;
        ldata = {{48{~zext & lanes[15]}}, lanes[15:0]};
      end
      (size == SZ_W): begin
        base  = 8'h0f;
        ldata = {{32{~zext & lanes[31]}}, lanes[31:0]};
      end
      default: begin
        base  = 8'hff;
        ldata = lanes;
      end
    endcase
    bmask  = 8'(base << offset);
    wshift = wdata << sh;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request per handshake, fixed
// access latency, RV64 sized loads/stores with error flag.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_DW = 1024,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_DW);

  dmem_state_t state;
  logic [3:0]  cnt;

  logic        cap_we;
  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;
  logic [2:0]  cap_func3;

  logic [63:0] mem [DEPTH_DW];

  logic        op_we;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;
  logic [2:0]  op_func3;

  logic          fire;
  logic          commit;
  logic          acc_err;
  logic [AW-1:0] idx;
  mem_size_t     size;
  logic [7:0]    bmask;
  logic [63:0]   wshift;
  logic [63:0]   ldata;
  logic [63:0]   acc_rdata;

  assign req_ready = reset && (state == IDLE);
  assign fire      = req_valid && req_ready;

  // With zero latency the access happens on the accept edge itself,
  // so the live request feeds the datapath instead of the capture regs.
  always_comb begin
    op_we    = cap_we;
    op_addr  = cap_addr;
    op_wdata = cap_wdata;
    op_func3 = cap_func3;
    if (state == IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_func3 = req_func3;
    end
  end

  assign size = mem_size_t'(op_func3[1:0]);
  assign idx  = op_addr[3 +: AW];

  assign acc_err = (op_func3 == F3_BAD)
                 | (op_we & op_func3[2])
                 | ~is_aligned(op_addr[2:0], size)
                 | (op_addr[63:3] >= 61'(DEPTH_DW));

  assign commit = (LATENCY == 0) ? fire
                                 : (state == WAIT && cnt == 4'd0);

  assign acc_rdata = (acc_err | op_we) ? '0 : ldata;

  dmem_lane_align u_align (
    .offset (op_addr[2:0]),
    .size   (size),
    .zext   (op_func3[2]),
    .wdata  (op_wdata),
    .rword  (mem[idx]),
    .bmask  (bmask),
    .wshift (wshift),
    .ldata  (ldata)
  );

  always_ff @(posedge clk) begin
    if (commit && op_we && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        if (bmask[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_func3 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_func3 <= req_func3;
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= acc_rdata;
              rsp_err   <= acc_err;
            end else begin
              cnt   <= 4'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_rdata;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference
// model, random traffic, backpressure and mid-transaction reset.
module tb_dmem_responder;

  localparam int DEPTH_DW = 1024;
  localparam int LATENCY  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_func3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_DW(DEPTH_DW), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  bit [7:0] mm [bit [63:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit have = 0;
  bit hs = 0;
  bit stall_on = 0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: memory is a flat byte map, sizes are 1/2/4/8 bytes.
  task automatic model(input bit we, input logic [63:0] a,
                       input logic [63:0] wd, input logic [2:0] f3,
                       output logic [63:0] rd, output logic err);
    int sz;
    sz  = 1 << f3[1:0];
    rd  = '0;
    err = (f3 == 3'b111) || (we && f3[2]) ||
          ((a % sz) != 0) || ((a / 8) >= DEPTH_DW);
    if (err) return;
    for (int i = 0; i < sz; i++) begin
      if (we) mm[a + i] = wd[8*i +: 8];
      else rd[8*i +: 8] = mm.exists(a + i) ? mm[a + i] : 8'h00;
    end
    if (we) rd = '0;
    else if (!f3[2] && sz < 8 && rd[8*sz-1]) begin
      for (int i = 8 * sz; i < 64; i++) rd[i] = 1'b1;
    end
  endtask

  task automatic issue(input bit we, input logic [63:0] a,
                       input logic [63:0] wd, input logic [2:0] f3,
                       input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_func3 = f3;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=busy required=ready");
      req_valid = 1'b0;
      return;
    end
    if (push) begin
      model(we, a, wd, f3, e.rdata, e.err);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_func3 = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || have || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=pending required=idle");
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      have = 0;
      hs = 0;
      rsp_ready = 1'b0;
    end else begin
      if (have) begin
        if (hs) begin
          chk("release_valid", 64'(rsp_valid), 64'd0);
          chk("release_ready", 64'(req_ready), 64'd1);
          have = 0;
        end else begin
          chk("hold_valid", 64'(rsp_valid), 64'd1);
          chk("hold_rdata", rsp_rdata, cur.rdata);
          chk("hold_err", 64'(rsp_err), 64'(cur.err));
          chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
      end
      if (!have && rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=valid required=idle");
        end else begin
          cur = q.pop_front();
          have = 1;
          chk("rdata", rsp_rdata, cur.rdata);
          chk("err", 64'(rsp_err), 64'(cur.err));
          chk("latency", 64'(cyc - cur.acc), 64'(LATENCY));
        end
      end
      if (have && stall_on) rsp_ready = 1'b0;
      else rsp_ready = ($urandom_range(0, 3) != 0);
      hs = have && rsp_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [2:0]  f3;
    int          sz;
    int          n;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_valid", 64'(rsp_valid), 64'd0);

    for (int i = 0; i < 16; i++)
      issue(1, 64'(i * 8), {$urandom, $urandom}, 3'b011, 1);

    issue(1, 64'h10, 64'h1122334455667788, 3'b011, 1);
    issue(0, 64'h10, 64'h0, 3'b011, 1);
    issue(1, 64'h13, 64'hAB, 3'b000, 1);
    issue(0, 64'h10, 64'h0, 3'b011, 1);
    issue(0, 64'h13, 64'h0, 3'b000, 1);
    issue(0, 64'h13, 64'h0, 3'b100, 1);
    issue(0, 64'h12, 64'h0, 3'b001, 1);
    issue(0, 64'h12, 64'h0, 3'b101, 1);
    issue(0, 64'h12, 64'h0, 3'b010, 1);
    issue(0, 64'h10, 64'h0, 3'b110, 1);
    issue(1, 64'(DEPTH_DW * 8), 64'hFFFFFFFFFFFFFFFF, 3'b011, 1);
    issue(0, 64'h0, 64'h0, 3'b011, 1);
    issue(1, 64'h18, 64'h5A5A, 3'b101, 1);
    issue(0, 64'h18, 64'h0, 3'b111, 1);
    issue(0, 64'h18, 64'h0, 3'b011, 1);

    drain();
    stall_on = 1;
    issue(0, 64'h10, 64'h0, 3'b011, 1);
    n = 0;
    while (!have && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_seen", 64'(have), 64'd1);
    repeat (5) @(negedge clk);
    stall_on = 0;

    drain();
    issue(1, 64'h20, 64'hDEADBEEFCAFEF00D, 3'b011, 0);
    reset = 1'b0;
    #1;
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_still_quiet", 64'(rsp_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", 64'(req_ready), 64'd1);
    issue(0, 64'h20, 64'h0, 3'b011, 1);

    for (int t = 0; t < 300; t++) begin
      f3 = 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      a  = 64'($urandom_range(0, 15) * 8);
      if ($urandom_range(0, 4) != 0)
        a = a + 64'(($urandom_range(0, 7) / sz) * sz);
      else
        a = a + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0)
        a = 64'(DEPTH_DW * 8) + 64'($urandom_range(0, 4095));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, f3, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
